rr_arb_param: RTL

Parametrised N-requester round-robin arbiter with a registered one-hot grant and a bounded grant-hold (burst) limit. It is the generalised successor to the fixed 3-requester arbiter. It adds configurable requester count, multi-cycle grant ownership capped at MAX_HOLD cycles, an arbitration enable, and an encoded grant ID. It sits between N bus masters and a shared resource.

---
 rtl/rr_arb_param.sv | 95 +++++++++
 1 files changed

// File: rtl/rr_arb_param.sv
// N-requester round-robin arbiter with a registered one-hot grant, an encoded
// grant ID and a bounded burst (hold) limit before forced rotation.
module rr_arb_param #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4,
  parameter int ID_W     = $clog2(N)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            arb_en,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic            gnt_vld,
  output logic [ID_W-1:0] gnt_id
);

  localparam int              CNT_W   = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);
  localparam logic [ID_W-1:0]  PTR_RST = ID_W'(N - 1);

  logic [N-1:0]     r_gnt;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  r_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic             w_vld;
  logic             w_own_req;
  logic             w_others;
  logic             w_hold;
  logic             w_force;
  logic [N-1:0]     w_cand;
  logic             w_found;
  logic [ID_W-1:0]  w_win;
  logic [N-1:0]     w_onehot;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_vld     = |r_gnt;
  assign w_own_req = |(req & r_gnt);
  assign w_others  = |(req & ~r_gnt);

  // The counter saturates, so "cnt < MAX_HOLD" is simply "cnt != MAX_HOLD".
  assign w_hold  = w_vld && w_own_req && ((r_cnt != CNT_MAX) || !w_others);
  assign w_force = w_vld && w_own_req && w_others && (r_cnt == CNT_MAX);

  // A forced rotation removes the owner from the candidate set; otherwise the
  // owner sits at r_ptr and is reached last by the circular search.
  assign w_cand = w_force ? (req & ~r_gnt) : req;

  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!w_found && w_cand[ID_W'(idx)]) begin
        w_found = 1'b1;
        w_win   = ID_W'(idx);
      end
    end
  end

  assign w_onehot  = N'(1) << w_win;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_gnt <= '0;
      r_id  <= '0;
      r_ptr <= PTR_RST;
      r_cnt <= '0;
    end else if (!arb_en) begin
      r_gnt <= '0;
      r_id  <= '0;
      r_cnt <= '0;
    end else if (w_hold) begin
      r_cnt <= w_cnt_inc;
    end else if (w_found) begin
      r_gnt <= w_onehot;
      r_id  <= w_win;
      r_ptr <= w_win;
      r_cnt <= CNT_W'(1);
    end else begin
      r_gnt <= '0;
      r_id  <= '0;
      r_cnt <= '0;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_vld = w_vld;
  assign gnt_id  = r_id;

endmodule
